// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Binary index of a one-hot vector; OR-ing the set positions is exact for one-hot input.
  function automatic logic [SEL_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-facing bundle of the arbiter: request vector in, grant/select/status out.
// Handshake: a source holds req[i] high for as long as it wants the mux; it owns the
// mux in every cycle where gnt[i] is high, and ownership ends on the edge after it
// drops req[i] (or after a timeout preempts it, flagged by a one-cycle preempt pulse).
interface mux4_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             preempt;
  state_e           dbg_state;

  modport master (
    output req,
    input  gnt, sel, sel_valid, preempt, dbg_state
  );

  modport slave (
    input  req,
    output gnt, sel, sel_valid, preempt, dbg_state
  );

endinterface

// File: rtl/mux_4to1.sv
// One-bit 4:1 multiplexer driven by the arbiter select.
module mux_4to1 (
  input  logic [3:0] a,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = a[sel];

endmodule

// File: rtl/rr_pick4.sv
// Combinational circular priority picker: first set request scanning from ptr upward.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [SEL_W-1:0] pick_idx,
  output logic             pick_any
);

  // Walk ptr, ptr+1, ... (mod 4) and latch the first requester found.
  always_comb begin : p_scan
    logic [SEL_W-1:0] cand;
    cand     = '0;
    pick_oh  = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!pick_any && req[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
        pick_oh  = N_REQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold time, sharing one mux_4to1 among four sources.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input logic                clk,
  input logic                rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic              preempt_q, preempt_d;
  logic [SEL_W-1:0]  own_idx_d;

  logic [SEL_W-1:0]  owner;
  logic [SEL_W-1:0]  owner_next;
  logic              owner_req;
  logic              timeout;

  logic [N_REQ-1:0]  seed_oh, alt_oh;
  logic [SEL_W-1:0]  seed_idx, alt_idx;
  logic              seed_any, alt_any;

  assign owner      = onehot2idx(gnt_q);
  assign owner_next = owner + SEL_W'(1);
  assign owner_req  = |(bus.req & gnt_q);
  assign timeout    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  // Fresh pick from the rotating pointer, used when leaving idle.
  rr_pick4 u_pick_seed (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_oh  (seed_oh),
    .pick_idx (seed_idx),
    .pick_any (seed_any)
  );

  // Successor pick: everyone but the current owner, starting just after it.
  rr_pick4 u_pick_alt (
    .req      (bus.req & ~gnt_q),
    .ptr      (owner_next),
    .pick_oh  (alt_oh),
    .pick_idx (alt_idx),
    .pick_any (alt_any)
  );

  // State, pointer, hold counter and registered outputs; reset aborts any grant silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  // Grant decision: idle pick, release hand-off, hold counting and timeout preemption.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    own_idx_d  = owner;
    preempt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (seed_any) begin
          gnt_d      = seed_oh;
          own_idx_d  = seed_idx;
          state_d    = ST_GRANT;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          // Release wins over a coincident timeout, so no preempt here.
          ptr_d      = owner_next;
          hold_cnt_d = '0;
          if (alt_any) begin
            gnt_d     = alt_oh;
            own_idx_d = alt_idx;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (timeout) begin
          // With nobody waiting the owner simply restarts its hold window.
          hold_cnt_d = '0;
          if (alt_any) begin
            gnt_d     = alt_oh;
            own_idx_d = alt_idx;
            ptr_d     = owner_next;
            preempt_d = 1'b1;
          end
        end else if (MAX_HOLD != 0) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Select outputs follow the new grant; sel keeps its last value while idle.
  always_comb begin
    sel_valid_d = |gnt_d;
    sel_d       = sel_valid_d ? own_idx_d : sel_q;
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.preempt   = preempt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed scoreboard bench for mux4_rr_arbiter feeding a mux_4to1.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int W = 9;  // {y, preempt, sel_valid, sel[1:0], gnt[3:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] a_vec = 4'b1010;
  logic y;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  string        phase = "init";
  logic [1:0]   last_sel = 2'b00;

  // Clock / reset
  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .MAX_HOLD (8),
    .HOLD_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_4to1 u_mux (
    .a   (a_vec),
    .sel (bus.sel),
    .y   (y)
  );

  // Driver: apply one cycle of inputs at negedge and queue the expected post-edge outputs.
  task automatic step(input logic rn, input logic [3:0] r,
                      input logic [3:0] eg, input logic ep);
    logic [1:0] es;
    logic       ev;
    logic       ey;
    @(negedge clk);
    rst_n   = rn;
    bus.req = r;
    ev = |eg;
    if (!rn)     es = 2'b00;
    else if (ev) es = onehot2idx(eg);
    else         es = last_sel;
    last_sel = es;
    ey = ev ? a_vec[es] : 1'b0;
    exp_q.push_back({ey, ep, ev, es, eg});
    tag_q.push_back(phase);
  endtask

  // Monitor / scoreboard: compare DUT outputs just after every edge that has an expectation.
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act_v = {(bus.sel_valid ? y : 1'b0), bus.preempt, bus.sel_valid, bus.sel, bus.gnt};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got {y,pre,vld,sel,gnt}=%b expected %b at %0t",
                   tag, act_v, exp_v, $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bus.req = 4'b0000;

    phase = "reset_hold";
    repeat (3) step(1'b0, 4'b1111, 4'b0000, 1'b0);

    phase = "rotate";
    step(1'b1, 4'b1111, 4'b0001, 1'b0);
    step(1'b1, 4'b1110, 4'b0010, 1'b0);
    step(1'b1, 4'b1101, 4'b0100, 1'b0);
    step(1'b1, 4'b1011, 4'b1000, 1'b0);
    step(1'b1, 4'b0111, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    phase = "single_req";
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    phase = "reset_ptr";
    step(1'b0, 4'b0000, 4'b0000, 1'b0);

    phase = "timeout";
    repeat (8) step(1'b1, 4'b1010, 4'b0010, 1'b0);
    step(1'b1, 4'b1010, 4'b1000, 1'b1);
    repeat (7) step(1'b1, 4'b1010, 4'b1000, 1'b0);
    step(1'b1, 4'b1010, 4'b0010, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    phase = "solo_hold";
    repeat (20) step(1'b1, 4'b0001, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    phase = "mid_reset";
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 4'b0000, 1'b0);
    step(1'b1, 4'b1111, 4'b0001, 1'b0);
    step(1'b1, 4'b1110, 4'b0010, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Drain: the last expectation is consumed one edge after it was queued.
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
